// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Round-robin arbiter for the single register-file writeback port shared
//   by the execution-unit controllers (ALU, mul/div, load/store, CSR).
//   Each unit pulls its active-low request low together with the destination
//   register it is about to write. One winner per cycle is acknowledged
//   combinationally. The winner is then registered as a one-hot writeback-mux
//   select for the following cycle, in which the granted unit drives the data.
//
// Parameters
//   REQ      number of requesting execution units (2..8)
//   RF_ADDR  register-file index width
//   CNT      statistics counter width (present only with WB_ARB_STATS_EN)
//
// Ports
//   clk          clock
//   reset_       asynchronous reset, active-low
//   flush_       pipeline flush, active-low; suppresses all grants
//   req_         per-unit writeback request, active-low
//   pre_rd       per-unit pending destination register, slice i = [i*RF_ADDR +: RF_ADDR]
//   ack_         per-unit grant, active-low, same cycle as the request
//   grant_       active-low, low when any ack_ bit is low
//   grant_rd     destination register of the current winner, 0 when idle
//   wb_sel       registered one-hot select of the unit writing back this cycle
//   wb_valid_    registered, active-low, low when wb_sel is non-zero
//   rr_ptr       current round-robin priority index
//   grant_cnt    (WB_ARB_STATS_EN) per-unit saturating grant counters
//   conflict_cnt (WB_ARB_STATS_EN) saturating count of cycles with 2+ requesters
//
// Optional feature macro: WB_ARB_STATS_EN adds the statistics counters.
// Arbitration behaves identically with or without it.

module wb_arbiter #(
  parameter int REQ     = 4,
  parameter int RF_ADDR = 5
`ifdef WB_ARB_STATS_EN
  ,
  parameter int CNT     = 32
`endif
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     flush_,
  input  logic [REQ-1:0]           req_,
  input  logic [REQ*RF_ADDR-1:0]   pre_rd,
  output logic [REQ-1:0]           ack_,
  output logic                     grant_,
  output logic [RF_ADDR-1:0]       grant_rd,
  output logic [REQ-1:0]           wb_sel,
  output logic                     wb_valid_,
  output logic [$clog2(REQ)-1:0]   rr_ptr
`ifdef WB_ARB_STATS_EN
  ,
  output logic [REQ*CNT-1:0]       grant_cnt,
  output logic [CNT-1:0]           conflict_cnt
`endif
);

  localparam int PTR_W = $clog2(REQ);

  logic [REQ-1:0]   grant_vec;
  logic             found;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] next_ptr;
  logic [PTR_W:0]   scan_sum;
  logic [PTR_W-1:0] scan_idx;

  // Round-robin search: walk the units starting at rr_ptr and wrapping
  // modulo REQ; the first low request wins. The sum is kept one bit wider
  // than the pointer so the wrap also works when REQ is not a power of two.
  // Reset and flush both gate the search, so no ack_ can leak out while the
  // arbiter is being cleared.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_sum = '0;
    scan_idx = '0;
    if (reset_ && flush_) begin
      for (int k = 0; k < REQ; k++) begin
        scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
        if (scan_sum >= (PTR_W+1)'(REQ))
          scan_sum = scan_sum - (PTR_W+1)'(REQ);
        scan_idx = scan_sum[PTR_W-1:0];
        if (!found && !req_[scan_idx]) begin
          found  = 1'b1;
          winner = scan_idx;
        end
      end
    end
  end

  // Decode the winner into the one-hot grant vector and pick out its pending
  // destination register for early bypass and wakeup. Both stay zero when
  // there is no winner.
  always_comb begin
    grant_vec = '0;
    grant_rd  = '0;
    if (found)
      grant_vec[winner] = 1'b1;
    for (int i = 0; i < REQ; i++) begin
      if (grant_vec[i])
        grant_rd = pre_rd[i*RF_ADDR +: RF_ADDR];
    end
  end

  assign ack_     = ~grant_vec;
  assign grant_   = ~found;
  assign next_ptr = (winner == PTR_W'(REQ-1)) ? '0 : winner + 1'b1;

  // Priority pointer and writeback select. The pointer moves just past the
  // winner so that unit becomes lowest priority next cycle. A cycle with no
  // grant (idle or flushed) leaves the pointer alone and clears the select.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rr_ptr    <= '0;
      wb_sel    <= '0;
      wb_valid_ <= 1'b1;
    end else begin
      wb_sel    <= grant_vec;
      wb_valid_ <= ~found;
      if (found)
        rr_ptr <= next_ptr;
    end
  end

`ifdef WB_ARB_STATS_EN
  logic multi_req;

  assign multi_req = flush_ && ($countones(~req_) >= 2);

  // Saturating statistics counters. They are cleared only by reset, so a
  // flush does not lose the history collected so far.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      grant_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      for (int i = 0; i < REQ; i++) begin
        if (grant_vec[i] && (grant_cnt[i*CNT +: CNT] != {CNT{1'b1}}))
          grant_cnt[i*CNT +: CNT] <= grant_cnt[i*CNT +: CNT] + 1'b1;
      end
      if (multi_req && (conflict_cnt != {CNT{1'b1}}))
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single register-file writeback port among REQ execution-unit controllers (ALU, mul/div, load/store, CSR).
- Each controller raises an active-low writeback request together with its pre-writeback destination register.
- The arbiter grants exactly one requester per cycle, combinationally and round-robin.
- It registers the winner as a one-hot writeback-mux select for the following cycle, in which the granted unit drives wb_e_/wb_data.

Parameters:
REQ, 4, number of requesting execution units (2..8)
RF_ADDR, 5, register-file index width
CNT, 32, statistics counter width (used only with WB_ARB_STATS_EN)

Ports:
clk  input  1  clock
reset_  input  1  reset, asynchronous, active-low
flush_  input  1  pipeline flush, active-low; suppresses all grants
req_  input  REQ  per-unit writeback request, active-low (bit i = unit i)
pre_rd  input  REQ*RF_ADDR  per-unit pending destination register; slice i = bits [i*RF_ADDR +: RF_ADDR]
ack_  output  REQ  per-unit grant, active-low, combinational, same cycle as request
grant_  output  1  active-low; low when any ack_ bit is low
grant_rd  output  RF_ADDR  pre_rd slice of the current winner; 0 when no grant (for early bypass/wakeup)
wb_sel  output  REQ  registered one-hot select of the unit writing back this cycle; all-zero when idle
wb_valid_  output  1  registered, active-low; low when wb_sel is non-zero
rr_ptr  output  log2(REQ)  current round-robin priority index (debug/observability)

Behaviour:
- Reset (reset_ low, asynchronous):
  - rr_ptr=0, wb_sel=0, wb_valid_=1.
  - ack_ all 1, grant_=1, grant_rd=0 while reset_ is low.
- Arbitration (combinational):
  - Among bits with req_[i]=0, select the first index found scanning i = rr_ptr, rr_ptr+1, ... modulo REQ.
  - Drive ack_[winner]=0; all other ack_ bits stay 1.
  - At most one ack_ bit is ever 0.
- No request (req_ all 1): ack_ all 1, grant_=1, grant_rd=0.
- Flush (flush_=0):
  - ack_ all 1 regardless of req_.
  - Next edge: wb_sel<=0, wb_valid_<=1, rr_ptr unchanged.
  - Flush has priority over any simultaneous request.
- Pointer update:
  - On a clock edge with a grant to index w: rr_ptr <= (w+1) mod REQ. Wrap from REQ-1 to 0.
  - On no grant, rr_ptr holds.
- Writeback select:
  - Each edge: wb_sel <= one-hot of the grant vector (inverted ack_), wb_valid_ <= grant_.
  - Latency from req_ low to the matching wb_sel bit is 1 cycle.
- Back-to-back:
  - A unit requesting continuously with no competitor is granted every cycle; wb_sel holds that bit.
  - With contention, each of k continuously requesting units is granted once every k cycles; worst-case wait is REQ-1 cycles.
- Ungranted requester holds req_ low and pre_rd stable; the arbiter keeps no per-requester request state.
- Request deasserted without grant: no effect on arbiter state.
- Async reset mid-arbitration: all state returns to reset values immediately; no grant is issued in the reset cycle.
- No combinational path from ack_ back to req_ inside the arbiter.

Optional Feature:
WB_ARB_STATS_EN:
- Defined:
  - Adds output grant_cnt (REQ*CNT), incremented per unit on each granted cycle.
  - Adds output conflict_cnt (CNT), incremented on each cycle with two or more req_ bits low and flush_=1.
  - Both counters reset to 0 on reset_ only (not on flush) and saturate at all-ones.
- Undefined: the ports and counters are absent; arbitration behaviour is identical.

Test Plan:
- Reset, then req_=4'b1110, pre_rd[0]=5'd7 -> ack_=4'b1110, grant_rd=7, grant_=0; next cycle wb_sel=4'b0001, wb_valid_=0, rr_ptr=1.
- req_=4'b0000 held 8 cycles from rr_ptr=0 -> grant order 0,1,2,3,0,1,2,3; wb_sel one-hot follows one cycle later; conflict_cnt=8 with WB_ARB_STATS_EN.
- rr_ptr=3, req_=4'b0110 (units 0 and 3) -> unit 3 granted, rr_ptr wraps to 0; next cycle unit 0 granted.
- flush_=0 with req_=4'b0000 -> ack_=4'b1111, grant_rd=0; next cycle wb_sel=0, wb_valid_=1, rr_ptr unchanged.
- reset_ pulsed low mid-stream with wb_sel=4'b0100 -> wb_sel=0, wb_valid_=1, rr_ptr=0 asynchronously; grant_cnt/conflict_cnt=0.
- req_ all 1 for 5 cycles -> ack_ all 1, rr_ptr constant, wb_valid_=1 throughout.
